sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Per-scanline sprite scheduler for the sprite engine. During horizontal blanking it scans the sprite descriptor table in index order and picks up to SLOTS sprites that overlap the next logical line. It fetches each chosen sprite's 8-bit row from the bitmap store over a req/ack handshake, then commits the result into double-buffered slot registers at the start of the active line. The pixel datapath reads only the committed slots, so it never indexes full 64-bit bitmaps combinationally.

## Interface
- NUM_SPRITES, 8: descriptor table depth; IDXW = clog2(NUM_SPRITES).
- SLOTS, 2: maximum sprites displayed per logical line.
- clk  in  1  pixel/system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scheduler enable (control_reg[0]).
- hblank_start  in  1  one-cycle pulse: prepare next line.
- line_start  in  1  one-cycle pulse: commit pending slots to active.
- next_line  in  8  logical Y of the line being prepared; stable from hblank_start to line_start.
- desc_idx  out  IDXW  descriptor read address.
- desc_en, desc_x[7:0], desc_y[7:0]  in  1/8/8  descriptor fields, combinational read of desc_idx, same cycle.
- row_req  out  1  bitmap row request.
- row_sprite  out  IDXW  sprite index of the request.
- row_sel  out  3  row within the sprite.
- row_ack  in  1  row_data valid; accepted on the edge where row_req && row_ack.
- row_data  in  8  bitmap row; bit n = pixel column n.
- slot_valid  out  SLOTS  committed slot valid.
- slot_x  out  8*SLOTS  committed slot X, slot k at [8k+7:8k].
- slot_row  out  8*SLOTS  committed slot row bits.
- busy  out  1  FSM in SCAN or FETCH.
- overflow  out  1  sticky: a line had more than SLOTS hits.
- late  out  1  sticky: line_start or hblank_start arrived while busy.
- flag_clr  in  1  clears overflow and late.

## Operation
- FSM states: IDLE, SCAN, FETCH, DONE. All outputs reset to 0, state resets to IDLE.
- IDLE → SCAN on hblank_start. Pending slots are cleared, desc_idx = 0, and fill count = 0.
- SCAN evaluates one descriptor per cycle. Hit = desc_en && (next_line − desc_y) mod 256 < 8, which is 8-bit wrapping subtraction. Sprites with desc_y ≥ 249 wrap to lines 0..(desc_y−249).
- SCAN, hit, free slot: latch offset = (next_line − desc_y)[2:0] and go to FETCH.
- SCAN, hit, no free slot: set overflow and go to DONE. Lower index always wins.
- SCAN, no hit: desc_idx+1. After NUM_SPRITES−1, go to DONE.
- FETCH drives row_req=1, row_sprite=desc_idx, row_sel=offset.
- FETCH on handshake: write pending[fill] = {valid, desc_x, row_data}, fill+1, desc_idx+1, then return to SCAN, or go to DONE if this was the last index.
- line_start in any state: pending copies to active (slot_valid/x/row) and the FSM goes to IDLE.
  - If the FSM was in SCAN or FETCH, set late. Slots already filled are committed and the rest stay invalid.
  - row_req drops on that same edge. Dropping an unacknowledged request is legal.
- hblank_start while in SCAN/FETCH/DONE: set late and restart the scan as from IDLE.
- enable=0: FSM goes to IDLE, row_req=0, and active and pending slots clear on the next edge. Flags are retained.
- flag_clr and a same-cycle flag set: the set wins.

## Timing
- Scan costs 1 cycle per descriptor. A fetch costs 1 cycle plus ack wait; an ack in the request cycle costs zero extra cycles.
- Worst case from hblank_start to DONE: NUM_SPRITES + 1 + SLOTS × (1 + ack latency) cycles, far below the 320-clock XGA hblank.
- Active slot outputs update only on the line_start edge and are registered, with no combinational path from inputs.
- row_req, row_sprite and row_sel are held stable until the handshake.

## Configuration
- SPRITE_SCHED_FLIP_EN defined: adds input desc_flipx (1), read with the descriptor.
  - When set, row_data is bit-reversed on capture, and row_sel = 7 − offset if desc_flipy is also present. Both desc_flipx and desc_flipy are added.
- SPRITE_SCHED_FLIP_EN undefined: neither port exists and rows are captured unmodified.

## Structure
- Package sprite_pkg holds:
  - SPR_W = 8, SPR_H = 8, COORD_W = 8.
  - FSM state enum.
  - slot struct {valid, x[7:0], row[7:0]}.
- Sub-module sprite_slot_bank: the pending/active double buffer with write port (fill index, slot data), commit strobe and clear.
- The FSM, hit test and flags stay in the top module.

## Test plan
- Case 1: desc0 {en,x=10,y=20}, desc1 {en,x=30,y=22}, next_line=23, ack same cycle. Expect:
  - fetches row_sel 3 then 1;
  - after line_start, slot0 = {1,10,row}, slot1 = {1,30,row};
  - DONE reached within NUM_SPRITES+3 cycles.
- Case 2: three enabled sprites, all y=5, next_line=5. Expect slots to hold idx 0 and idx 1, overflow=1, and idx 2 never requested.
- Case 3: desc_y=252, next_line=2. Expect a hit with row_sel=6. With next_line=4, expect no hit.
- Case 4: ack delayed 400 cycles and line_start arrives mid-FETCH. Expect:
  - late=1;
  - row_req drops on that edge;
  - only slots filled before the stall are committed.
- Case 5: enable dropped mid-SCAN. Expect IDLE, row_req=0 and slot_valid=0 next cycle, with overflow and late unchanged. Then flag_clr clears them.
- Case 6 (SPRITE_SCHED_FLIP_EN defined): flipx with row_data=8'b0000_0001 captures 8'b1000_0000.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// sprite_pkg: shared sizes, FSM state encoding and slot record for the
// sprite line scheduler.                                        Rev 1.0
// ============================================================================
package sprite_pkg;

  localparam int SPR_W   = 8;
  localparam int SPR_H   = 8;
  localparam int COORD_W = 8;
  localparam int ROW_W   = $clog2(SPR_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [SPR_W-1:0]   row;
  } slot_t;

  function automatic logic [SPR_W-1:0] bit_reverse(input logic [SPR_W-1:0] v);
    logic [SPR_W-1:0] r;
    for (int b = 0; b < SPR_W; b++) r[b] = v[SPR_W-1-b];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_slot_bank.sv
`default_nettype none
// ============================================================================
// sprite_slot_bank: pending/active slot double buffer; the scheduler fills
// pending slots, a commit strobe copies them to the registered active set.
// Rev 1.0
// ============================================================================
module sprite_slot_bank
  import sprite_pkg::*;
#(
  parameter int SLOTS = 2,
  parameter int FILLW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_all,
  input  logic                 clear_pend,
  input  logic                 wr_en,
  input  logic [FILLW-1:0]     wr_idx,
  input  slot_t                wr_slot,
  input  logic                 commit,
  output logic [SLOTS-1:0]     slot_valid,
  output logic [8*SLOTS-1:0]   slot_x,
  output logic [8*SLOTS-1:0]   slot_row
);

  slot_t pend_q [SLOTS];
  slot_t pend_d [SLOTS];
  slot_t act_q  [SLOTS];
  slot_t act_d  [SLOTS];

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (clear_all) begin
      for (int k = 0; k < SLOTS; k++) begin
        pend_d[k] = '0;
        act_d[k]  = '0;
      end
    end else begin
      // Commit reads the old pending contents, so a same-cycle write is not seen.
      if (commit) act_d = pend_q;
      if (clear_pend) begin
        for (int k = 0; k < SLOTS; k++) pend_d[k] = '0;
      end else if (wr_en) begin
        for (int k = 0; k < SLOTS; k++)
          if (wr_idx == FILLW'(k)) pend_d[k] = wr_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        pend_q[k] <= '0;
        act_q[k]  <= '0;
      end
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot_out
    assign slot_valid[k]       = act_q[k].valid;
    assign slot_x[8*k +: 8]    = act_q[k].x;
    assign slot_row[8*k +: 8]  = act_q[k].row;
  end

endmodule
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// sprite_line_scheduler: hblank scan of the descriptor table, row fetch over
// req/ack, commit to active slots on line_start.
// Optional: SPRITE_SCHED_FLIP_EN adds desc_flipx/desc_flipy.    Rev 1.0
// ============================================================================
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter  int NUM_SPRITES = 8,
  parameter  int SLOTS       = 2,
  localparam int IDXW        = $clog2(NUM_SPRITES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 hblank_start,
  input  logic                 line_start,
  input  logic [7:0]           next_line,
  output logic [IDXW-1:0]      desc_idx,
  input  logic                 desc_en,
  input  logic [7:0]           desc_x,
  input  logic [7:0]           desc_y,
`ifdef SPRITE_SCHED_FLIP_EN
  input  logic                 desc_flipx,
  input  logic                 desc_flipy,
`endif
  output logic                 row_req,
  output logic [IDXW-1:0]      row_sprite,
  output logic [2:0]           row_sel,
  input  logic                 row_ack,
  input  logic [7:0]           row_data,
  output logic [SLOTS-1:0]     slot_valid,
  output logic [8*SLOTS-1:0]   slot_x,
  output logic [8*SLOTS-1:0]   slot_row,
  output logic                 busy,
  output logic                 overflow,
  output logic                 late,
  input  logic                 flag_clr
);

  localparam int FILLW = $clog2(SLOTS + 1);

  sched_state_e     state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [FILLW-1:0] fill_q, fill_d;
  logic [ROW_W-1:0] offset_q, offset_d;
  logic             overflow_q, overflow_d;
  logic             late_q, late_d;

  logic             clear_all, clear_pend, commit, wr_en;
  logic [COORD_W-1:0] dy;
  logic             hit, last_idx, busy_w;
  logic [SPR_W-1:0] row_cap;
  slot_t            wr_slot;

  // Wrapping distance handles sprites straddling line 255 -> 0.
  assign dy       = next_line - desc_y;
  assign hit      = desc_en && (dy < COORD_W'(SPR_H));
  assign last_idx = (idx_q == IDXW'(NUM_SPRITES - 1));
  assign busy_w   = (state_q == ST_SCAN) || (state_q == ST_FETCH);

`ifdef SPRITE_SCHED_FLIP_EN
  logic flipx_q, flipx_d;
  logic [ROW_W-1:0] scan_off;
  assign scan_off = desc_flipy ? ~dy[ROW_W-1:0] : dy[ROW_W-1:0];
  assign row_cap  = flipx_q ? bit_reverse(row_data) : row_data;
`else
  logic [ROW_W-1:0] scan_off;
  assign scan_off = dy[ROW_W-1:0];
  assign row_cap  = row_data;
`endif

  always_comb begin
    wr_slot.valid = 1'b1;
    wr_slot.x     = desc_x;
    wr_slot.row   = row_cap;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    offset_d   = offset_q;
    overflow_d = overflow_q & ~flag_clr;
    late_d     = late_q & ~flag_clr;
    clear_all  = 1'b0;
    clear_pend = 1'b0;
    commit     = 1'b0;
    wr_en      = 1'b0;
`ifdef SPRITE_SCHED_FLIP_EN
    flipx_d    = flipx_q;
`endif
    if (!enable) begin
      state_d   = ST_IDLE;
      clear_all = 1'b1;
    end else if (line_start) begin
      commit  = 1'b1;
      state_d = ST_IDLE;
      if (busy_w) late_d = 1'b1;
    end else if (hblank_start) begin
      if (state_q != ST_IDLE) late_d = 1'b1;
      state_d    = ST_SCAN;
      idx_d      = '0;
      fill_d     = '0;
      clear_pend = 1'b1;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            if (fill_q < FILLW'(SLOTS)) begin
              offset_d = scan_off;
`ifdef SPRITE_SCHED_FLIP_EN
              flipx_d  = desc_flipx;
`endif
              state_d  = ST_FETCH;
            end else begin
              overflow_d = 1'b1;
              state_d    = ST_DONE;
            end
          end else if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
        ST_FETCH: begin
          // desc_idx is unchanged since the hit, so desc_x is still valid here.
          if (row_ack) begin
            wr_en  = 1'b1;
            fill_d = fill_q + FILLW'(1);
            if (last_idx) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDXW'(1);
              state_d = ST_SCAN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      fill_q     <= '0;
      offset_q   <= '0;
      overflow_q <= 1'b0;
      late_q     <= 1'b0;
`ifdef SPRITE_SCHED_FLIP_EN
      flipx_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_q     <= fill_d;
      offset_q   <= offset_d;
      overflow_q <= overflow_d;
      late_q     <= late_d;
`ifdef SPRITE_SCHED_FLIP_EN
      flipx_q    <= flipx_d;
`endif
    end
  end

  assign desc_idx   = idx_q;
  assign row_req    = (state_q == ST_FETCH);
  assign row_sprite = idx_q;
  assign row_sel    = offset_q;
  assign busy       = busy_w;
  assign overflow   = overflow_q;
  assign late       = late_q;

  sprite_slot_bank #(
    .SLOTS (SLOTS),
    .FILLW (FILLW)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_all  (clear_all),
    .clear_pend (clear_pend),
    .wr_en      (wr_en),
    .wr_idx     (fill_q),
    .wr_slot    (wr_slot),
    .commit     (commit),
    .slot_valid (slot_valid),
    .slot_x     (slot_x),
    .slot_row   (slot_row)
  );

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sprite_line_scheduler: directed lines against a per-line hit-list model
// of the scheduler, with a bitmap-store responder.               Rev 1.0
// ============================================================================
module tb_sprite_line_scheduler;

  localparam int NS    = 8;
  localparam int SL    = 2;
  localparam int IDXW  = 3;

  logic            clk, rst_n, enable, hblank_start, line_start, flag_clr;
  logic [7:0]      next_line;
  logic [IDXW-1:0] desc_idx;
  logic            desc_en;
  logic [7:0]      desc_x, desc_y;
  logic            row_req, row_ack;
  logic [IDXW-1:0] row_sprite;
  logic [2:0]      row_sel;
  logic [7:0]      row_data;
  logic [SL-1:0]   slot_valid;
  logic [8*SL-1:0] slot_x, slot_row;
  logic            busy, overflow, late;

  logic       d_en [NS];
  logic [7:0] d_x  [NS];
  logic [7:0] d_y  [NS];
  assign desc_en = d_en[desc_idx];
  assign desc_x  = d_x[desc_idx];
  assign desc_y  = d_y[desc_idx];

`ifdef SPRITE_SCHED_FLIP_EN
  logic d_fx [NS];
  logic d_fy [NS];
  logic desc_flipx, desc_flipy;
  assign desc_flipx = d_fx[desc_idx];
  assign desc_flipy = d_fy[desc_idx];
`endif

  sprite_line_scheduler #(.NUM_SPRITES(NS), .SLOTS(SL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hblank_start(hblank_start), .line_start(line_start), .next_line(next_line),
    .desc_idx(desc_idx), .desc_en(desc_en), .desc_x(desc_x), .desc_y(desc_y),
`ifdef SPRITE_SCHED_FLIP_EN
    .desc_flipx(desc_flipx), .desc_flipy(desc_flipy),
`endif
    .row_req(row_req), .row_sprite(row_sprite), .row_sel(row_sel),
    .row_ack(row_ack), .row_data(row_data),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_row(slot_row),
    .busy(busy), .overflow(overflow), .late(late), .flag_clr(flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] cur_line;
  int         hit_q[$];
  logic       use_one = 1'b0;
  logic [SL-1:0]   exp_valid = '0;
  logic [8*SL-1:0] exp_x = '0, exp_row = '0;

  function automatic logic [7:0] row_mem(input int s, input logic [2:0] r);
    logic [31:0] sv;
    sv = s;
    return {1'b1, sv[2:0], 1'b0, r};
  endfunction

  function automatic logic [2:0] model_sel(input int s, input logic [7:0] line);
    logic [7:0] d;
    d = line - d_y[s];
`ifdef SPRITE_SCHED_FLIP_EN
    if (d_fy[s]) return 3'd7 - d[2:0];
`endif
    return d[2:0];
  endfunction

  function automatic logic [7:0] model_row(input int s, input logic [7:0] line);
    logic [7:0] r, rr;
    r  = use_one ? 8'h01 : row_mem(s, model_sel(s, line));
    rr = r;
`ifdef SPRITE_SCHED_FLIP_EN
    if (d_fx[s]) for (int b = 0; b < 8; b++) rr[b] = r[7-b];
`endif
    return rr;
  endfunction

  // Hit list in index order for one line.
  task automatic model_line(input logic [7:0] line);
    int d;
    cur_line = line;
    next_line = line;
    hit_q.delete();
    for (int s = 0; s < NS; s++) begin
      d = (int'(line) - int'(d_y[s]) + 256) % 256;
      if (d_en[s] && d < 8) hit_q.push_back(s);
    end
  endtask

  task automatic commit_model(input int n);
    exp_valid = '0; exp_x = '0; exp_row = '0;
    for (int k = 0; k < SL; k++)
      if (k < n && k < hit_q.size()) begin
        exp_valid[k]     = 1'b1;
        exp_x[8*k +: 8]  = d_x[hit_q[k]];
        exp_row[8*k +: 8] = model_row(hit_q[k], cur_line);
      end
  endtask

  // ---------------- bitmap store responder ----------------
  int   stall_idx = -1;
  int   wait_cnt  = 0;
  int   log_sprite[$];
  int   log_sel[$];
  logic req_seen [NS];

  always @(negedge clk) begin
    if (row_req) begin
      req_seen[row_sprite] = 1'b1;
      if (wait_cnt >= ((int'(row_sprite) == stall_idx) ? 400 : 0)) begin
        row_ack  = 1'b1;
        row_data = use_one ? 8'h01 : row_mem(int'(row_sprite), row_sel);
        log_sprite.push_back(int'(row_sprite));
        log_sel.push_back(int'(row_sel));
      end else begin
        row_ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      row_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("slot_valid", 32'(slot_valid), 32'(exp_valid));
      check("slot_x",     32'(slot_x),     32'(exp_x));
      check("slot_row",   32'(slot_row),   32'(exp_row));
      if (row_req) begin
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < hit_q.size() && k < SL; k++)
          if (hit_q[k] == int'(row_sprite)) ok = 1'b1;
        check("req_sprite_allowed", 32'(ok), 32'd1);
        check("req_row_sel", 32'(row_sel), 32'(model_sel(int'(row_sprite), cur_line)));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    log_sprite.delete();
    log_sel.delete();
    for (int s = 0; s < NS; s++) req_seen[s] = 1'b0;
  endtask

  task automatic set_desc(input int s, input logic en, input logic [7:0] x, input logic [7:0] y);
    d_en[s] = en; d_x[s] = x; d_y[s] = y;
  endtask

  task automatic clear_descs();
    for (int s = 0; s < NS; s++) begin
      set_desc(s, 1'b0, 8'd0, 8'd0);
`ifdef SPRITE_SCHED_FLIP_EN
      d_fx[s] = 1'b0; d_fy[s] = 1'b0;
`endif
    end
  endtask

  task automatic pulse_hblank();
    @(posedge clk); #1 hblank_start = 1'b1;
    @(posedge clk); #1 hblank_start = 1'b0;
  endtask

  task automatic pulse_line(input int n_commit);
    @(posedge clk); #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    commit_model(n_commit);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    logic ok;
    ok = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; hblank_start = 1'b0; line_start = 1'b0;
    flag_clr = 1'b0; next_line = 8'd0; row_ack = 1'b0; row_data = 8'd0;
    cur_line = 8'd0;
    clear_descs();
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_desc_idx",  32'(desc_idx), 0);
    check("rst_row_req",   32'(row_req), 0);
    check("rst_slot_valid", 32'(slot_valid), 0);
    check("rst_slot_x",    32'(slot_x), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_late",      32'(late), 0);
    @(posedge clk); #1 rst_n = 1'b1; enable = 1'b1;
    chk_on = 1'b1;

    // Case 1: two overlapping sprites, ack in request cycle.
    set_desc(0, 1'b1, 8'd10, 8'd20);
    set_desc(1, 1'b1, 8'd30, 8'd22);
    model_line(8'd23);
    clear_log();
    pulse_hblank();
    wait_idle(NS + 3, "c1_done_in_budget");
    pulse_line(SL);
    check("c1_nreq", 32'(log_sel.size()), 2);
    if (log_sel.size() >= 2) begin
      check("c1_req0_sprite", 32'(log_sprite[0]), 0);
      check("c1_req0_sel",    32'(log_sel[0]), 3);
      check("c1_req1_sprite", 32'(log_sprite[1]), 1);
      check("c1_req1_sel",    32'(log_sel[1]), 1);
    end
    @(negedge clk);
    check("c1_slot_valid", 32'(slot_valid), 32'h3);
    check("c1_slot_x",     32'(slot_x), 32'h1E0A);
    check("c1_slot_row",   32'(slot_row), 32'h9183);
    check("c1_overflow",   32'(overflow), 0);
    check("c1_late",       32'(late), 0);

    // Case 2: three hits on one line; the lowest two win.
    clear_descs();
    set_desc(0, 1'b1, 8'd40, 8'd5);
    set_desc(1, 1'b1, 8'd50, 8'd5);
    set_desc(2, 1'b1, 8'd60, 8'd5);
    model_line(8'd5);
    clear_log();
    pulse_hblank();
    wait_idle(20, "c2_done");
    pulse_line(SL);
    @(negedge clk);
    check("c2_overflow",   32'(overflow), 1);
    check("c2_idx2_never", 32'(req_seen[2]), 0);
    check("c2_slot_x",     32'(slot_x), 32'h3228);

    // Case 3: sprite wrapping past line 255.
    clear_descs();
    set_desc(0, 1'b1, 8'd100, 8'd252);
    model_line(8'd2);
    clear_log();
    pulse_hblank();
    wait_idle(20, "c3a_done");
    pulse_line(SL);
    check("c3a_nreq", 32'(log_sel.size()), 1);
    if (log_sel.size() >= 1) check("c3a_sel", 32'(log_sel[0]), 6);
    @(negedge clk);
    check("c3a_valid", 32'(slot_valid), 32'h1);
    model_line(8'd4);
    clear_log();
    pulse_hblank();
    wait_idle(20, "c3b_done");
    pulse_line(SL);
    @(negedge clk);
    check("c3b_nreq",  32'(log_sel.size()), 0);
    check("c3b_valid", 32'(slot_valid), 0);

    // Case 4: second fetch stalls, line_start lands mid-FETCH.
    clear_descs();
    set_desc(0, 1'b1, 8'd70, 8'd50);
    set_desc(1, 1'b1, 8'd80, 8'd50);
    model_line(8'd50);
    clear_log();
    stall_idx = 1;
    pulse_hblank();
    repeat (20) @(negedge clk);
    check("c4_stalled_req",    32'(row_req), 1);
    check("c4_stalled_sprite", 32'(row_sprite), 1);
    check("c4_late_before",    32'(late), 0);
    pulse_line(1);
    @(negedge clk);
    check("c4_req_dropped", 32'(row_req), 0);
    check("c4_late",        32'(late), 1);
    check("c4_valid",       32'(slot_valid), 32'h1);
    stall_idx = -1;

    // Case 5: enable dropped mid-SCAN; flags survive, then flag_clr.
    clear_descs();
    model_line(8'd0);
    pulse_hblank();
    repeat (2) @(negedge clk);
    check("c5_busy_scan", 32'(busy), 1);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 commit_model(0);
    @(negedge clk);
    check("c5_busy",     32'(busy), 0);
    check("c5_row_req",  32'(row_req), 0);
    check("c5_valid",    32'(slot_valid), 0);
    check("c5_overflow", 32'(overflow), 1);
    check("c5_late",     32'(late), 1);
    @(posedge clk); #1 enable = 1'b1; flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    @(negedge clk);
    check("c5_overflow_clr", 32'(overflow), 0);
    check("c5_late_clr",     32'(late), 0);

`ifdef SPRITE_SCHED_FLIP_EN
    // Case 6: horizontal flip reverses the captured row.
    clear_descs();
    set_desc(0, 1'b1, 8'd5, 8'd0);
    d_fx[0] = 1'b1;
    use_one = 1'b1;
    model_line(8'd0);
    clear_log();
    pulse_hblank();
    wait_idle(20, "c6_done");
    pulse_line(SL);
    @(negedge clk);
    check("c6_flip_row", 32'(slot_row[7:0]), 32'h80);
    use_one = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
